// File: rtl/risc_ctrl_pkg.sv
// Shared types and encodings for the risc_ctrl_seq control sequencer.
// Optional illegal-instruction trap: RISC_CTRL_ILLEGAL_TRAP_EN.
package risc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPD_PC, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B,
        S_EXEC, S_WR_REG, S_MEM_ADDR, S_LD_ADDR, S_MEM_RD, S_MEM_WB,
        S_STR_B, S_STR_C, S_MEM_WR, S_HALT
    } state_t;

    // Instruction class captured in DECODE; steers the shared states later on.
    typedef enum logic [2:0] {
        EX_NONE, EX_IMM, EX_MOV, EX_ALU, EX_CMP, EX_LDR, EX_STR
    } exec_t;

    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_MEM     = 2'b00;

    localparam logic [1:0] NSEL_RM = 2'b00;
    localparam logic [1:0] NSEL_RD = 2'b01;
    localparam logic [1:0] NSEL_RN = 2'b10;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    function automatic exec_t exec_kind(input logic [2:0] opc, input logic [1:0] op);
        exec_t k;
        k = EX_NONE;
        case (opc)
            OPC_MOV: begin
                if (op == OP_MOV_IMM)      k = EX_IMM;
                else if (op == OP_MOV_REG) k = EX_MOV;
            end
            OPC_ALU: k = (op == OP_CMP) ? EX_CMP : EX_ALU;
            OPC_LDR: if (op == OP_MEM) k = EX_LDR;
            OPC_STR: if (op == OP_MEM) k = EX_STR;
            default: k = EX_NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/risc_ctrl_out.sv
// Pure state-to-output decoder for risc_ctrl_seq; EXEC is refined by the
// registered instruction class, so outputs still depend on registers only.
module risc_ctrl_out
    import risc_ctrl_pkg::*;
(
    input  state_t     i_state,
    input  exec_t      i_exec,
    output logic       o_asel,
    output logic       o_bsel,
    output logic       o_loada,
    output logic       o_loadb,
    output logic       o_loadc,
    output logic       o_loads,
    output logic       o_write,
    output logic [1:0] o_nsel,
    output logic [1:0] o_vsel,
    output logic       o_load_ir,
    output logic       o_load_pc,
    output logic       o_reset_pc,
    output logic       o_load_addr,
    output logic       o_addr_sel,
    output logic [1:0] o_mem_cmd,
    output logic       o_halted
);

    always_comb begin
        o_asel      = 1'b0;
        o_bsel      = 1'b0;
        o_loada     = 1'b0;
        o_loadb     = 1'b0;
        o_loadc     = 1'b0;
        o_loads     = 1'b0;
        o_write     = 1'b0;
        o_nsel      = NSEL_RM;
        o_vsel      = VSEL_C;
        o_load_ir   = 1'b0;
        o_load_pc   = 1'b0;
        o_reset_pc  = 1'b0;
        o_load_addr = 1'b0;
        o_addr_sel  = 1'b0;
        o_mem_cmd   = MEM_NONE;
        o_halted    = 1'b0;
        case (i_state)
            S_RST:      begin o_reset_pc = 1'b1; o_load_pc = 1'b1; end
            S_IF1:      begin o_addr_sel = 1'b1; o_mem_cmd = MEM_READ; end
            S_IF2:      begin o_addr_sel = 1'b1; o_mem_cmd = MEM_READ; o_load_ir = 1'b1; end
            S_UPD_PC:   o_load_pc = 1'b1;
            S_WR_IMM:   begin o_nsel = NSEL_RN; o_vsel = VSEL_IMM; o_write = 1'b1; end
            S_GET_A:    begin o_nsel = NSEL_RN; o_loada = 1'b1; end
            S_GET_B:    begin o_nsel = NSEL_RM; o_loadb = 1'b1; end
            S_EXEC: begin
                o_loadc = (i_exec != EX_CMP);
                o_loads = (i_exec == EX_ALU) || (i_exec == EX_CMP);
                o_asel  = (i_exec == EX_MOV);
            end
            S_WR_REG:   begin o_nsel = NSEL_RD; o_vsel = VSEL_C; o_write = 1'b1; end
            S_MEM_ADDR: begin o_bsel = 1'b1; o_loadc = 1'b1; end
            S_LD_ADDR:  o_load_addr = 1'b1;
            S_MEM_RD:   o_mem_cmd = MEM_READ;
            S_MEM_WB: begin
                o_mem_cmd = MEM_READ;
                o_nsel    = NSEL_RD;
                o_vsel    = VSEL_MDATA;
                o_write   = 1'b1;
            end
            S_STR_B:    begin o_nsel = NSEL_RD; o_loadb = 1'b1; end
            S_STR_C:    begin o_asel = 1'b1; o_loadc = 1'b1; end
            S_MEM_WR:   o_mem_cmd = MEM_WRITE;
            S_HALT:     o_halted = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: rtl/risc_ctrl_seq.sv
// Multi-cycle fetch/decode/execute sequencer for the RISC datapath.
// Define RISC_CTRL_ILLEGAL_TRAP_EN to halt (illegal=1) on unknown encodings.
module risc_ctrl_seq
    import risc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       asel,
    output logic       bsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       write,
    output logic [1:0] nsel,
    output logic [1:0] vsel,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       load_addr,
    output logic       addr_sel,
    output logic [1:0] mem_cmd,
    output logic       halted,
    output logic       illegal
);

    localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

    state_t     r_state;
    state_t     w_next;
    exec_t      r_exec;
    exec_t      w_kind;
    logic [3:0] r_wait;
    logic       w_waiting;
    logic       w_wait_done;

    assign w_kind      = exec_kind(opcode, op);
    assign w_waiting   = (r_state == S_IF1) || (r_state == S_MEM_RD);
    assign w_wait_done = (r_wait == LAT_LAST);

    // Counter runs only in the two memory-wait states, so it is 0 on entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_RST;
            r_wait  <= '0;
            r_exec  <= EX_NONE;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_waiting && !w_wait_done) ? r_wait + 4'd1 : '0;
            if (r_state == S_DECODE) r_exec <= w_kind;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:      w_next = S_IF1;
            S_IF1:      if (w_wait_done) w_next = S_IF2;
            S_IF2:      w_next = S_UPD_PC;
            S_UPD_PC:   w_next = S_DECODE;
            S_DECODE: begin
                case (w_kind)
                    EX_IMM:  w_next = S_WR_IMM;
                    EX_MOV:  w_next = S_GET_B;
                    EX_ALU, EX_CMP, EX_LDR, EX_STR: w_next = S_GET_A;
                    default: begin
                        if (opcode == OPC_HALT) w_next = S_HALT;
`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
                        else                    w_next = S_HALT;
`else
                        else                    w_next = S_IF1;
`endif
                    end
                endcase
            end
            S_WR_IMM:   w_next = S_IF1;
            S_GET_A:    w_next = (r_exec == EX_LDR || r_exec == EX_STR) ? S_MEM_ADDR : S_GET_B;
            S_GET_B:    w_next = S_EXEC;
            S_EXEC:     w_next = (r_exec == EX_CMP) ? S_IF1 : S_WR_REG;
            S_WR_REG:   w_next = S_IF1;
            S_MEM_ADDR: w_next = S_LD_ADDR;
            S_LD_ADDR:  w_next = (r_exec == EX_LDR) ? S_MEM_RD : S_STR_B;
            S_MEM_RD:   if (w_wait_done) w_next = S_MEM_WB;
            S_MEM_WB:   w_next = S_IF1;
            S_STR_B:    w_next = S_STR_C;
            S_STR_C:    w_next = S_MEM_WR;
            S_MEM_WR:   w_next = S_IF1;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_RST;
        endcase
    end

`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_illegal <= 1'b0;
        end else if (r_state == S_DECODE && w_kind == EX_NONE && opcode != OPC_HALT) begin
            r_illegal <= 1'b1;
        end
    end
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    risc_ctrl_out u_out (
        .i_state     (r_state),
        .i_exec      (r_exec),
        .o_asel      (asel),
        .o_bsel      (bsel),
        .o_loada     (loada),
        .o_loadb     (loadb),
        .o_loadc     (loadc),
        .o_loads     (loads),
        .o_write     (write),
        .o_nsel      (nsel),
        .o_vsel      (vsel),
        .o_load_ir   (load_ir),
        .o_load_pc   (load_pc),
        .o_reset_pc  (reset_pc),
        .o_load_addr (load_addr),
        .o_addr_sel  (addr_sel),
        .o_mem_cmd   (mem_cmd),
        .o_halted    (halted)
    );

endmodule

// File: doc/risc_ctrl_seq.md
# risc_ctrl_seq

Parametrised multi-cycle control sequencer for the RISC datapath. It fetches instructions from memory and sequences decode, execute and write-back for MOV, ALU, LDR, STR and HALT. It drives the existing datapath control set (asel, bsel, loada, loadb, loadc, loads, write, nsel, vsel) plus the program-counter, instruction-register and memory controls. It is the successor of the four-state execute-only controller and adds fetch, memory access with configurable latency, and halt.

## Interface
Parameters:
- MEM_LAT, 1, read latency in cycles from mem_cmd=READ to valid data (legal 1..15)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- opcode  in  3  instruction register bits [15:13]
- op  in  2  instruction register bits [12:11]; for opcode 101 it is the ALU op (00 ADD, 01 CMP, 10 AND, 11 MVN)
- asel, bsel  out  1  datapath operand selects (1 = zero / sximm5)
- loada, loadb, loadc, loads  out  1  datapath register enables
- write  out  1  register-file write enable
- nsel  out  2  register select: 00 Rm, 01 Rd, 10 Rn
- vsel  out  2  write-back source: 00 C, 01 PC, 10 sximm8, 11 mdata
- load_ir, load_pc, reset_pc, load_addr  out  1  IR, PC and data-address enables
- addr_sel  out  1  memory address mux: 1 = PC, 0 = data address
- mem_cmd  out  2  00 NONE, 01 READ, 10 WRITE
- halted  out  1  high in HALT
- illegal  out  1  high in HALT when it was entered on an illegal instruction (macro only)

## Operation
- Moore machine. State is registered, and all outputs decode from state only. Any output not listed for a state is 0.
- States and asserted outputs:
  - RST: reset_pc, load_pc.
  - IF1: addr_sel, mem_cmd=READ.
  - IF2: addr_sel, mem_cmd=READ, load_ir.
  - UPD_PC: load_pc.
  - DECODE: none.
  - WR_IMM: nsel=Rn, vsel=10, write.
  - GET_A: nsel=Rn, loada.
  - GET_B: nsel=Rm, loadb.
  - EXEC: loadc, with asel=1 for MOV Rd,Rm. For ALU ops, EXEC also asserts loads; for CMP it asserts loads only, with no loadc.
  - WR_REG: nsel=Rd, vsel=00, write.
  - MEM_ADDR: bsel, loadc.
  - LD_ADDR: load_addr.
  - MEM_RD: mem_cmd=READ.
  - MEM_WB: mem_cmd=READ, nsel=Rd, vsel=11, write.
  - STR_B: nsel=Rd, loadb.
  - STR_C: asel, loadc.
  - MEM_WR: mem_cmd=WRITE.
  - HALT: halted.
- Transitions:
  - RST → IF1.
  - IF1 → IF2 after MEM_LAT cycles. A wait counter clears on entry and compares to MEM_LAT-1.
  - IF2 → UPD_PC → DECODE.
- Transitions out of DECODE:
  - 110/10 → WR_IMM → IF1.
  - 110/00 → GET_B → EXEC → WR_REG → IF1.
  - 101/op other than 01 → GET_A → GET_B → EXEC → WR_REG → IF1.
  - 101/01 (CMP) → GET_A → GET_B → EXEC → IF1.
  - 011/00 (LDR) → GET_A → MEM_ADDR → LD_ADDR → MEM_RD (held MEM_LAT cycles) → MEM_WB → IF1.
  - 100/00 (STR) → GET_A → MEM_ADDR → LD_ADDR → STR_B → STR_C → MEM_WR → IF1.
  - 111 → HALT.
  - Any other encoding is illegal; see Configuration.
- HALT is absorbing and exits only on reset.
- opcode and op are sampled only in DECODE; changes in other states are ignored.

## Timing
- While reset is low, state is RST immediately (asynchronous). Outputs are then reset_pc=1, load_pc=1, all others 0, and halted=0, illegal=0. The wait counter is 0.
- Reset asserted mid-instruction aborts it immediately. No partial write is held, because write drops in the same cycle.
- The first IF1 is the first rising edge after reset deasserts.
- Instruction latency in cycles, counted from the first cycle of IF1 to the first cycle of the next IF1:
  - Fetch overhead: MEM_LAT+3.
  - MOV imm: +1.
  - MOV reg: +3.
  - ALU: +4.
  - CMP: +3.
  - LDR: MEM_LAT+4.
  - STR: +6.
- mem_cmd=WRITE is asserted for exactly one cycle per STR.
- During LDR, mem_cmd=READ is continuous from the first cycle of MEM_RD through MEM_WB.

## Configuration
- RISC_CTRL_ILLEGAL_TRAP_EN defined: an illegal encoding in DECODE goes to HALT with illegal=1, registered and held until reset.
- Undefined: an illegal encoding is a NOP, DECODE → IF1, and the illegal output is tied to 0.

## Structure
- Shared package risc_ctrl_pkg holds:
  - the state enum;
  - opcode/op constants;
  - nsel constants RM/RD/RN;
  - vsel constants;
  - mem_cmd constants.
- One sub-module, risc_ctrl_out, is the pure state-to-output decoder. The top holds the state register, wait counter and next-state logic.

## Test plan
- Reset low for 2 cycles, then released → reset_pc=1, load_pc=1 during reset. The first edge gives IF1 with addr_sel=1, mem_cmd=01, and IF1 lasts MEM_LAT cycles (test MEM_LAT=1 and 3).
- Apply MOV R?,#imm (opcode 110, op 10) with MEM_LAT=1 → WR_IMM has nsel=10, vsel=10, write=1. The next IF1 follows 5 cycles after the previous IF1.
- Apply ADD (101/00) then CMP (101/01) → ADD: EXEC has loadc=1, loads=1, then WR_REG has nsel=01, write=1. CMP: EXEC has loads=1, loadc=0, and no write occurs before IF1.
- Apply LDR (011/00) with MEM_LAT=3 → MEM_RD holds 3 cycles with addr_sel=0, then MEM_WB has vsel=11, write=1. STR (100/00) gives exactly one cycle of mem_cmd=10.
- Apply HALT (111), then hold for 10 cycles → halted=1 and state stays constant. Drive reset low → RST immediately, with halted=0.
- Apply opcode 000 → with the macro: HALT, illegal=1. Without it: next state IF1, illegal=0. Asserting reset in MEM_RD → write=0 and mem_cmd=00 in the same cycle.
